// File: rtl/dft_frame_ctrl.sv
// dft_frame_ctrl: sequences one DFT frame at a time. It waits for the core to
// be ready, streams the sample ROM into it (1-cycle ROM latency), then collects
// the N_BINS output bins into a registered result stream.
// Optional build macro DFT_FRAME_CTRL_WATCHDOG_EN adds a no-progress watchdog
// on the two waiting states; without it those states wait indefinitely.
module dft_frame_ctrl #(
  parameter int          N_BINS    = 24,
  parameter int          ADDR_W    = 5,
  parameter int          DATA_W    = 18,
  parameter logic [5:0]  SIZE_CODE = 6'd1,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     fwd_inv_in,
  input  logic                     rffd,
  input  logic                     data_valid,
  input  logic signed [DATA_W-1:0] xk_re,
  input  logic signed [DATA_W-1:0] xk_im,
  input  logic [3:0]               blk_exp,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     fd_in,
  output logic                     fwd_inv,
  output logic [5:0]               size,
  output logic                     sclr,
  output logic [ADDR_W-1:0]        bin_idx,
  output logic signed [DATA_W-1:0] bin_re,
  output logic signed [DATA_W-1:0] bin_im,
  output logic [3:0]               bin_exp,
  output logic                     bin_valid,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_PRIME    = 3'd2;
  localparam logic [2:0] S_LOAD     = 3'd3;
  localparam logic [2:0] S_WAIT_OUT = 3'd4;
  localparam logic [2:0] S_UNLOAD   = 3'd5;
  localparam logic [2:0] S_ERR      = 3'd6;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_BINS - 1);

  logic [2:0]               state_q, state_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic                     fd_in_q, fd_in_d;
  logic                     fwd_inv_q, fwd_inv_d;
  logic                     sclr_q, sclr_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]        bin_idx_q, bin_idx_d;
  logic signed [DATA_W-1:0] bin_re_q, bin_re_d;
  logic signed [DATA_W-1:0] bin_im_q, bin_im_d;
  logic [3:0]               bin_exp_q, bin_exp_d;
  logic                     bin_valid_q, bin_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     err_q, err_d;
  logic                     err_hit;
  logic [ADDR_W-1:0]        cap_idx;
  logic                     wd_expire;

  // Saturating increment so the bin/load counters can never wrap past the last bin.
  function automatic logic [ADDR_W-1:0] cnt_inc(input logic [ADDR_W-1:0] c);
    return (c == LAST) ? LAST : c + 1'b1;
  endfunction

`ifdef DFT_FRAME_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            waiting;

  assign waiting   = ((state_q == S_WAIT_RDY) && !rffd) ||
                     ((state_q == S_WAIT_OUT) && !data_valid);
  assign wd_expire = waiting && (wd_q == WD_W'(TIMEOUT - 1));

  // Count consecutive stalled cycles; any progress or state change clears it.
  always_ff @(posedge clk) begin
    if (!reset_n)                   wd_q <= '0;
    else if (waiting && !wd_expire) wd_q <= wd_q + 1'b1;
    else                            wd_q <= '0;
  end
`else
  // No watchdog: TIMEOUT is irrelevant and the waiting states never expire.
  assign wd_expire = 1'b0 && (TIMEOUT > 0);
`endif

  // Next-state and output decode for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = '0;
    fd_in_d      = 1'b0;
    fwd_inv_d    = fwd_inv_q;
    sclr_d       = 1'b0;
    cnt_d        = cnt_q;
    bin_idx_d    = bin_idx_q;
    bin_re_d     = bin_re_q;
    bin_im_d     = bin_im_q;
    bin_exp_d    = bin_exp_q;
    bin_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;
    err_hit      = 1'b0;
    cap_idx      = (state_q == S_WAIT_OUT) ? '0 : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          err_hit = 1'b1;
        end else if (start || cont) begin
          fwd_inv_d = fwd_inv_in;
          state_d   = S_WAIT_RDY;
          if (start) err_d = 1'b0;
        end
      end
      S_WAIT_RDY: begin
        if (data_valid)     err_hit = 1'b1;
        else if (rffd)      state_d = S_PRIME;
        else if (wd_expire) err_hit = 1'b1;
      end
      S_PRIME: begin
        // ROM word 0 lands on the DFT input together with fd_in next cycle.
        if (data_valid) begin
          err_hit = 1'b1;
        end else begin
          mem_addr_d = ADDR_W'(1);
          fd_in_d    = 1'b1;
          cnt_d      = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (data_valid) begin
          err_hit = 1'b1;
        end else if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_OUT;
        end else begin
          cnt_d      = cnt_inc(cnt_q);
          mem_addr_d = (mem_addr_q == LAST || mem_addr_q == '0) ? '0 : mem_addr_q + 1'b1;
        end
      end
      S_WAIT_OUT, S_UNLOAD: begin
        if (data_valid) begin
          bin_idx_d   = cap_idx;
          bin_re_d    = xk_re;
          bin_im_d    = xk_im;
          bin_exp_d   = blk_exp;
          bin_valid_d = 1'b1;
          if (cap_idx == LAST) begin
            frame_done_d = 1'b1;
            cnt_d        = '0;
            state_d      = cont ? S_WAIT_RDY : S_IDLE;
          end else begin
            cnt_d   = cnt_inc(cap_idx);
            state_d = S_UNLOAD;
          end
        end else if (wd_expire) begin
          err_hit = 1'b1;
        end
      end
      S_ERR: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (err_hit) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      sclr_d  = 1'b1;
      cnt_d   = '0;
    end
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= '0;
      fd_in_q      <= 1'b0;
      fwd_inv_q    <= 1'b1;
      sclr_q       <= 1'b1;
      cnt_q        <= '0;
      bin_idx_q    <= '0;
      bin_re_q     <= '0;
      bin_im_q     <= '0;
      bin_exp_q    <= '0;
      bin_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      fd_in_q      <= fd_in_d;
      fwd_inv_q    <= fwd_inv_d;
      sclr_q       <= sclr_d;
      cnt_q        <= cnt_d;
      bin_idx_q    <= bin_idx_d;
      bin_re_q     <= bin_re_d;
      bin_im_q     <= bin_im_d;
      bin_exp_q    <= bin_exp_d;
      bin_valid_q  <= bin_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign fd_in      = fd_in_q;
  assign fwd_inv    = fwd_inv_q;
  assign size       = SIZE_CODE;
  assign sclr       = sclr_q;
  assign bin_idx    = bin_idx_q;
  assign bin_re     = bin_re_q;
  assign bin_im     = bin_im_q;
  assign bin_exp    = bin_exp_q;
  assign bin_valid  = bin_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_dft_frame_ctrl.sv
// Bench for dft_frame_ctrl: every accepted DFT output sample is pushed into an
// expectation queue; a negedge monitor pops and compares the bin stream.
module tb_dft_frame_ctrl;
  localparam int N  = 24;
  localparam int AW = 5;
  localparam int DW = 18;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n, start, cont, fwd_inv_in, rffd, data_valid;
  logic signed [DW-1:0] xk_re, xk_im;
  logic [3:0]           blk_exp;
  logic [AW-1:0]        mem_addr, bin_idx;
  logic                 fd_in, fwd_inv, sclr, bin_valid, busy, frame_done, err;
  logic [5:0]           size;
  logic signed [DW-1:0] bin_re, bin_im;
  logic [3:0]           bin_exp;

  dft_frame_ctrl #(.N_BINS(N), .ADDR_W(AW), .DATA_W(DW), .SIZE_CODE(6'd1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cont(cont), .fwd_inv_in(fwd_inv_in),
    .rffd(rffd), .data_valid(data_valid), .xk_re(xk_re), .xk_im(xk_im), .blk_exp(blk_exp),
    .mem_addr(mem_addr), .fd_in(fd_in), .fwd_inv(fwd_inv), .size(size), .sclr(sclr),
    .bin_idx(bin_idx), .bin_re(bin_re), .bin_im(bin_im), .bin_exp(bin_exp),
    .bin_valid(bin_valid), .busy(busy), .frame_done(frame_done), .err(err)
  );

  typedef struct {
    int                   idx;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [3:0]           ex;
    logic                 last;
  } bin_t;

  bin_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   fd_cnt = 0;
  int   bv_cnt = 0;
  int   idle_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare every presented bin against the scoreboard.
  always @(negedge clk) begin
    bin_t e;
    if (frame_done) begin
      fd_cnt++;
      check("fd_with_bin_valid", bin_valid, frame_done);
    end
    if (bin_valid) begin
      bv_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_bin_valid", bin_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("bin_idx", bin_idx, e.idx);
        check("bin_re", bin_re, e.re);
        check("bin_im", bin_im, e.im);
        check("bin_exp", bin_exp, e.ex);
        check("frame_done_last", frame_done, e.last);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_mem_addr", mem_addr, 0);
    check("rst_fd_in", fd_in, 0);
    check("rst_fwd_inv", fwd_inv, 1);
    check("rst_sclr", sclr, 1);
    check("rst_bin_idx", bin_idx, 0);
    check("rst_bin_re", bin_re, 0);
    check("rst_bin_im", bin_im, 0);
    check("rst_bin_exp", bin_exp, 0);
    check("rst_bin_valid", bin_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("size_code", size, 1);
  endtask

  // Start a frame (unless resuming after a continuous-mode frame end) and walk
  // up to WAIT_OUT. Cycle c counts edges since the request; LOAD spans c=3..N+2.
  task automatic launch(input bit from_frame_end, input bit use_start, input bit fwd, input bit chk);
    if (!from_frame_end) begin
      fwd_inv_in = fwd;
      start = use_start;
      tick();
      start = 1'b0;
    end
    for (int c = 1; c <= N + 3; c++) begin
      if (c > 1) tick();
      if (busy == 1'b0) idle_seen++;
      if (chk) begin
        check($sformatf("fd_in_c%0d", c), fd_in, (c == 3));
        check($sformatf("mem_addr_c%0d", c), mem_addr, (c >= 3 && c <= N + 1) ? c - 2 : 0);
      end
    end
  endtask

  // Feed N output samples with random gaps; scoreboard records each accepted one.
  task automatic unload(input bit toggle_fwd, input bit exp_fwd, input bit drop_cont);
    int got = 0;
    int cyc = 0;
    while (got < N && cyc < N * 20) begin
      bit dv;
      dv = (got == 0) || ($urandom_range(0, 2) != 0);
      if (toggle_fwd) fwd_inv_in = 1'($urandom_range(0, 1));
      start = (got > 0 && got < N - 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (busy == 1'b0) idle_seen++;
      if (dv) begin
        bin_t e;
        xk_re   = DW'($urandom);
        xk_im   = DW'($urandom);
        blk_exp = 4'($urandom);
        e.idx = got; e.re = xk_re; e.im = xk_im; e.ex = blk_exp; e.last = (got == N - 1);
        exp_q.push_back(e);
        data_valid = 1'b1;
        if (got == N / 2) check("fwd_inv_mid_frame", fwd_inv, exp_fwd);
        got++;
        if (got == N && drop_cont) cont = 1'b0;
      end else begin
        data_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    data_valid = 1'b0;
    start = 1'b0;
    check("unload_complete", got, N);
    check("fwd_inv_frame_end", fwd_inv, exp_fwd);
  endtask

  task automatic settle_and_count(input string tag, input int fd0, input int bv0, input int nfd);
    tick();
    tick();
    check({tag, "_frame_done_count"}, fd_cnt - fd0, nfd);
    check({tag, "_bin_valid_count"}, bv_cnt - bv0, nfd * N);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int fd0, bv0;
    reset_n = 1'b0; start = 1'b0; cont = 1'b0; fwd_inv_in = 1'b1; rffd = 1'b1;
    data_valid = 1'b0; xk_re = '0; xk_im = '0; blk_exp = '0;

    // Reset values
    tick(); tick();
    check_reset_vals();
    reset_n = 1'b1;
    tick();
    check("sclr_after_release", sclr, 0);
    check("busy_idle", busy, 0);

    // Single frame, forward=0, fwd_inv_in toggled while unloading
    fd0 = fd_cnt; bv0 = bv_cnt;
    launch(1'b0, 1'b1, 1'b0, 1'b1);
    check("busy_in_frame", busy, 1);
    unload(1'b1, 1'b0, 1'b0);
    settle_and_count("single_fwd0", fd0, bv0, 1);
    check("busy_after_frame", busy, 0);

    // Single frame, direction 1
    fd0 = fd_cnt; bv0 = bv_cnt;
    launch(1'b0, 1'b1, 1'b1, 1'b0);
    unload(1'b0, 1'b1, 1'b0);
    settle_and_count("single_fwd1", fd0, bv0, 1);

    // Continuous mode for three frames
    fd0 = fd_cnt; bv0 = bv_cnt; idle_seen = 0;
    cont = 1'b1;
    launch(1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      if (f > 0) launch(1'b1, 1'b0, 1'b0, 1'b1);
      unload(1'b1, 1'b0, (f == 2));
    end
    check("cont_no_idle_between", idle_seen, 0);
    settle_and_count("cont3", fd0, bv0, 3);
    check("cont_idle_after", busy, 0);

    // data_valid during LOAD -> error, one-cycle sclr, back to IDLE
    fd0 = fd_cnt; bv0 = bv_cnt;
    fwd_inv_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 8; c++) tick();
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("err_set", err, 1);
    check("err_sclr_pulse", sclr, 1);
    tick();
    check("err_sclr_one_cycle", sclr, 0);
    check("err_back_idle", busy, 0);
    tick(); tick();
    check("err_sticky", err, 1);
    check("err_no_frame_done", fd_cnt - fd0, 0);
    check("err_no_bins", bv_cnt - bv0, 0);

    // start in IDLE clears err and runs a clean frame
    fd0 = fd_cnt; bv0 = bv_cnt;
    launch(1'b0, 1'b1, 1'b0, 1'b0);
    check("err_cleared_by_start", err, 0);
    unload(1'b0, 1'b0, 1'b0);
    settle_and_count("after_err", fd0, bv0, 1);

    // Reset at LOAD cycle 10 aborts the frame
    fd0 = fd_cnt; bv0 = bv_cnt;
    fwd_inv_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 13; c++) tick();
    reset_n = 1'b0;
    tick();
    check_reset_vals();
    reset_n = 1'b1;
    tick();
    check("sclr_after_abort", sclr, 0);
    for (int i = 0; i < 40; i++) tick();
    check("abort_no_frame_done", fd_cnt - fd0, 0);
    check("abort_no_bins", bv_cnt - bv0, 0);

    // rffd held low after start
    rffd = 1'b0; fwd_inv_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
`ifdef DFT_FRAME_CTRL_WATCHDOG_EN
    for (int c = 2; c <= TO; c++) tick();
    check("wd_not_yet", err, 0);
    tick();
    check("wd_err", err, 1);
    check("wd_sclr", sclr, 1);
    tick();
    check("wd_idle", busy, 0);
    rffd = 1'b1;
`else
    for (int c = 2; c <= 40; c++) tick();
    check("no_wd_busy", busy, 1);
    check("no_wd_err", err, 0);
    fd0 = fd_cnt; bv0 = bv_cnt;
    rffd = 1'b1;
    for (int c = 0; c < N + 3; c++) tick();
    unload(1'b0, 1'b1, 1'b0);
    settle_and_count("late_rffd", fd0, bv0, 1);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
